// File: rtl/nubus_mem_pkg.sv
// Shared types and constants for the NuBus card memory master.
package nubus_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0]  WSTRB_NONE      = 4'b0000;
  localparam logic [3:0]  WSTRB_ALL       = 4'b1111;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/nubus_wait_timer.sv
// Bounded wait counter for a bus cycle; expire flags the last allowed wait cycle.
module nubus_wait_timer #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 8
) (
  input  logic mem_clk,
  input  logic mem_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset)   cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + TO_W'(1);
  end

  // expire is registered alongside cnt so it is high exactly when cnt == TIMEOUT-1
  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset)   expire <= 1'b0;
      else if (clear)  expire <= (LAST == '0);
      else if (enable) expire <= ((cnt + TO_W'(1)) == LAST);
    end
  end

endmodule

// File: rtl/nubus_mem_master.sv
// Single-outstanding valid/ready memory bus initiator with timeout and
// backpressured response port.
module nubus_mem_master
  import nubus_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 8
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_t      state, state_d;
  logic        is_write, is_write_d;
  logic        mem_valid_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [3:0]  mem_wstrb_d;
  logic        rsp_valid_d, rsp_error_d;
  logic [31:0] rsp_rdata_d;
  logic        tmr_clear, tmr_enable, tmr_expire;

  assign cmd_ready = (state == IDLE);

  nubus_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_wait_timer (
    .mem_clk  (mem_clk),
    .mem_reset(mem_reset),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .expire   (tmr_expire)
  );

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= WSTRB_NONE;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      is_write  <= is_write_d;
      mem_valid <= mem_valid_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      rsp_valid <= rsp_valid_d;
      rsp_error <= rsp_error_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  // Ready beats timeout in the same cycle; the timer only counts unacknowledged cycles.
  always_comb begin
    state_d     = state;
    is_write_d  = is_write;
    mem_valid_d = mem_valid;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    rsp_valid_d = rsp_valid;
    rsp_error_d = rsp_error;
    rsp_rdata_d = rsp_rdata;
    tmr_clear   = 1'b0;
    tmr_enable  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = cmd_addr & ADDR_ALIGN_MASK;
          mem_wdata_d = cmd_wdata;
          mem_wstrb_d = cmd_write ? cmd_wstrb : WSTRB_NONE;
          is_write_d  = cmd_write;
          tmr_clear   = 1'b1;
          state_d     = BUS;
        end
      end
      BUS: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = is_write ? 32'h0 : mem_rdata;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (tmr_expire) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
